// File: rtl/tlu_record_reader_if.sv
// Word-stream and record-output signals between the TLU record reader and its neighbours.
// The reader takes the master modport; the FIFO/consumer side takes the slave modport.
interface tlu_record_reader_if;
    logic        FIFO_EMPTY;
    logic [15:0] FIFO_DATA;
    logic        FIFO_READ;
    logic        REC_VALID;
    logic        REC_READY;
    logic [31:0] REC_LE;
    logic [63:0] REC_TIME_STAMP;
    logic [31:0] REC_TRIG_ID;

    modport master (
        input  FIFO_EMPTY, FIFO_DATA, REC_READY,
        output FIFO_READ, REC_VALID, REC_LE, REC_TIME_STAMP, REC_TRIG_ID
    );

    modport slave (
        output FIFO_EMPTY, FIFO_DATA, REC_READY,
        input  FIFO_READ, REC_VALID, REC_LE, REC_TIME_STAMP, REC_TRIG_ID
    );
endinterface

// File: rtl/tlu_record_reader.sv
// Assembles 8-word TLU records from a show-ahead FIFO, presents them on a valid/ready port
// and checks trigger-ID / timestamp continuity between consecutive records.
module tlu_record_reader #(
    parameter int GAP_CNT_WIDTH = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     RESYNC,
    input  logic                     CLR_CNT,
    tlu_record_reader_if.master      bus,
    output logic                     ID_GAP,
    output logic                     TS_ERR,
    output logic [31:0]              REC_CNT,
    output logic [GAP_CNT_WIDTH-1:0] GAP_CNT,
    output logic [7:0]               TS_ERR_CNT
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [GAP_CNT_WIDTH-1:0] GAP_MAX = '1;
    localparam logic [GAP_CNT_WIDTH-1:0] GAP_ONE = {{(GAP_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [2:0]               word_cnt_q, word_cnt_d;
    logic [6:0][15:0]         word_buf_q, word_buf_d;
    logic                     rec_valid_q, rec_valid_d;
    logic [31:0]              rec_le_q, rec_le_d;
    logic [63:0]              rec_ts_q, rec_ts_d;
    logic [31:0]              rec_id_q, rec_id_d;
    logic                     id_gap_q, id_gap_d;
    logic                     ts_err_q, ts_err_d;
    logic                     check_armed_q, check_armed_d;
    logic [31:0]              prev_id_q, prev_id_d;
    logic [63:0]              prev_ts_q, prev_ts_d;
    logic [31:0]              rec_cnt_q, rec_cnt_d;
    logic [GAP_CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]               ts_err_cnt_q, ts_err_cnt_d;

    logic                     fifo_read_s;
    logic                     complete_s;
    logic                     accept_s;
    logic [31:0]              new_id_s;
    logic [63:0]              new_ts_s;

    // Pop strobe: mid-record words are always drained, a new record needs EN; gated by RST
    always_comb begin
        fifo_read_s = 1'b0;
        if ((state_q == COLLECT) && !RST) begin
            fifo_read_s = !bus.FIFO_EMPTY && ((word_cnt_q != 3'd0) || EN);
        end else begin
            fifo_read_s = 1'b0;
        end
        complete_s = fifo_read_s && (word_cnt_q == 3'd7);
        accept_s   = (state_q == HOLD) && bus.REC_READY;
        new_id_s   = {bus.FIFO_DATA, word_buf_q[6]};
        new_ts_s   = {word_buf_q[5], word_buf_q[4], word_buf_q[3], word_buf_q[2]};
    end

    // Next-state, record assembly, continuity check and counters
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        word_buf_d  = word_buf_q;
        rec_valid_d = rec_valid_q;
        rec_le_d    = rec_le_q;
        rec_ts_d    = rec_ts_q;
        rec_id_d    = rec_id_q;
        id_gap_d    = 1'b0;
        ts_err_d    = 1'b0;
        prev_id_d   = prev_id_q;
        prev_ts_d   = prev_ts_q;

        case (state_q)
            COLLECT: begin
                if (fifo_read_s) begin
                    word_cnt_d = word_cnt_q + 3'd1;
                    if (word_cnt_q != 3'd7) begin
                        word_buf_d[word_cnt_q] = bus.FIFO_DATA;
                    end else begin
                        // Last word: every output field updates on the same edge as REC_VALID
                        state_d     = HOLD;
                        rec_valid_d = 1'b1;
                        rec_le_d    = {word_buf_q[1], word_buf_q[0]};
                        rec_ts_d    = new_ts_s;
                        rec_id_d    = new_id_s;
                        prev_id_d   = new_id_s;
                        prev_ts_d   = new_ts_s;
                        if (check_armed_q && !RESYNC) begin
                            id_gap_d = (new_id_s != (prev_id_q + 32'd1));
                            ts_err_d = (new_ts_s <= prev_ts_q);
                        end else begin
                            id_gap_d = 1'b0;
                            ts_err_d = 1'b0;
                        end
                    end
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            HOLD: begin
                if (bus.REC_READY) begin
                    state_d     = COLLECT;
                    rec_valid_d = 1'b0;
                    word_cnt_d  = 3'd0;
                end else begin
                    state_d     = HOLD;
                end
            end
            default: begin
                state_d     = COLLECT;
                word_cnt_d  = 3'd0;
                rec_valid_d = 1'b0;
            end
        endcase

        check_armed_d = RESYNC ? 1'b0 : (complete_s ? 1'b1 : check_armed_q);

        // Clear has priority over any coincident increment
        rec_cnt_d    = CLR_CNT ? 32'd0 : (accept_s ? (rec_cnt_q + 32'd1) : rec_cnt_q);
        gap_cnt_d    = CLR_CNT ? '0 :
                       ((id_gap_d && (gap_cnt_q != GAP_MAX)) ? (gap_cnt_q + GAP_ONE) : gap_cnt_q);
        ts_err_cnt_d = CLR_CNT ? 8'd0 :
                       ((ts_err_d && (ts_err_cnt_q != 8'hFF)) ? (ts_err_cnt_q + 8'd1) : ts_err_cnt_q);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q       <= COLLECT;
            word_cnt_q    <= 3'd0;
            word_buf_q    <= '0;
            rec_valid_q   <= 1'b0;
            rec_le_q      <= 32'd0;
            rec_ts_q      <= 64'd0;
            rec_id_q      <= 32'd0;
            id_gap_q      <= 1'b0;
            ts_err_q      <= 1'b0;
            check_armed_q <= 1'b0;
            prev_id_q     <= 32'd0;
            prev_ts_q     <= 64'd0;
            rec_cnt_q     <= 32'd0;
            gap_cnt_q     <= '0;
            ts_err_cnt_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            word_buf_q    <= word_buf_d;
            rec_valid_q   <= rec_valid_d;
            rec_le_q      <= rec_le_d;
            rec_ts_q      <= rec_ts_d;
            rec_id_q      <= rec_id_d;
            id_gap_q      <= id_gap_d;
            ts_err_q      <= ts_err_d;
            check_armed_q <= check_armed_d;
            prev_id_q     <= prev_id_d;
            prev_ts_q     <= prev_ts_d;
            rec_cnt_q     <= rec_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ts_err_cnt_q  <= ts_err_cnt_d;
        end
    end

    assign bus.FIFO_READ      = fifo_read_s;
    assign bus.REC_VALID      = rec_valid_q;
    assign bus.REC_LE         = rec_le_q;
    assign bus.REC_TIME_STAMP = rec_ts_q;
    assign bus.REC_TRIG_ID    = rec_id_q;
    assign ID_GAP             = id_gap_q;
    assign TS_ERR             = ts_err_q;
    assign REC_CNT            = rec_cnt_q;
    assign GAP_CNT            = gap_cnt_q;
    assign TS_ERR_CNT         = ts_err_cnt_q;

endmodule
